// File: rtl/reset_sequencer.sv
// Power-on reset sequencer: synchronises reset release and PLL lock, holds all
// channels in reset for a settle period, then releases them one by one.
module reset_sequencer #(
  parameter int                 NUM_OUT        = 4,
  parameter int                 SYNC_STAGES    = 2,
  parameter int                 LOCK_FILTER    = 4,
  parameter int                 HOLD_CYCLES    = 16,
  parameter int                 STAGE_GAP      = 8,
  parameter logic [NUM_OUT-1:0] OUT_RST_ACTIVE = {NUM_OUT{1'b1}}
) (
  input  logic               i_clk,
  input  logic               i_arstn,
  input  logic               i_lock,
  input  logic               i_sw_rst,
  output logic [NUM_OUT-1:0] o_srst,
  output logic               o_ready,
  output logic [2:0]         o_state
);

  localparam int LW = $clog2(LOCK_FILTER + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int GW = $clog2(STAGE_GAP + 1);
  localparam int IW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_HOLD      = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4
  } state_e;

  logic [SYNC_STAGES-1:0] rsync_q;
  logic [1:0]             lsync_q;
  logic [LW-1:0]          lcnt_q, lcnt_d;
  logic                   rst_done, lock_ok;

  state_e               state_q, state_d;
  logic [HW-1:0]        hcnt_q, hcnt_d;
  logic [GW-1:0]        gcnt_q, gcnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [NUM_OUT-1:0]   rel_q, rel_d;
  logic                 ready_q, ready_d;
  logic [NUM_OUT-1:0]   srst_q;

  // Reset release is delayed through the chain; assertion is immediate.
  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      rsync_q <= '0;
      lsync_q <= '0;
      lcnt_q  <= '0;
    end else begin
      rsync_q <= {rsync_q[SYNC_STAGES-2:0], 1'b1};
      lsync_q <= {lsync_q[0], i_lock};
      lcnt_q  <= lcnt_d;
    end
  end

  assign rst_done = rsync_q[SYNC_STAGES-1];
  assign lock_ok  = (lcnt_q == LW'(LOCK_FILTER));

  always_comb begin
    lcnt_d = lcnt_q;
    if (!lsync_q[1])   lcnt_d = '0;
    else if (!lock_ok) lcnt_d = lcnt_q + LW'(1);
  end

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    gcnt_d  = gcnt_q;
    idx_d   = idx_q;
    rel_d   = rel_q;
    ready_d = ready_q;
    case (state_q)
      ST_RESET: if (rst_done) state_d = ST_WAIT_LOCK;
      ST_WAIT_LOCK: if (lock_ok) begin
        state_d = ST_HOLD;
        hcnt_d  = '0;
      end
      ST_HOLD: begin
        if (hcnt_q == HW'(HOLD_CYCLES - 1)) begin
          rel_d[0] = 1'b1;
          gcnt_d   = '0;
          idx_d    = IW'(1);
          if (NUM_OUT == 1) begin
            state_d = ST_RUN;
            ready_d = 1'b1;
          end else begin
            state_d = ST_RELEASE;
          end
        end else begin
          hcnt_d = hcnt_q + HW'(1);
        end
      end
      ST_RELEASE: begin
        if (gcnt_q == GW'(STAGE_GAP - 1)) begin
          rel_d[idx_q] = 1'b1;
          gcnt_d       = '0;
          if (idx_q == IW'(NUM_OUT - 1)) begin
            state_d = ST_RUN;
            ready_d = 1'b1;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          gcnt_d = gcnt_q + GW'(1);
        end
      end
      ST_RUN: ;
      default: state_d = ST_RESET;
    endcase

    // Lock loss outranks a software reset request.
    if (state_q inside {ST_WAIT_LOCK, ST_HOLD, ST_RELEASE, ST_RUN}) begin
      if (!lock_ok) begin
        state_d = ST_WAIT_LOCK;
        rel_d   = '0;
        ready_d = 1'b0;
        hcnt_d  = '0;
        gcnt_d  = '0;
        idx_d   = '0;
      end else if (i_sw_rst && state_q != ST_WAIT_LOCK) begin
        state_d = ST_HOLD;
        rel_d   = '0;
        ready_d = 1'b0;
        hcnt_d  = '0;
        gcnt_d  = '0;
        idx_d   = '0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      state_q <= ST_RESET;
      hcnt_q  <= '0;
      gcnt_q  <= '0;
      idx_q   <= '0;
      rel_q   <= '0;
      ready_q <= 1'b0;
      srst_q  <= OUT_RST_ACTIVE;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      gcnt_q  <= gcnt_d;
      idx_q   <= idx_d;
      rel_q   <= rel_d;
      ready_q <= ready_d;
      srst_q  <= OUT_RST_ACTIVE ^ rel_d;
    end
  end

  assign o_srst  = srst_q;
  assign o_ready = ready_q;
  assign o_state = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench: segment table drives the main sequencer and a scoreboard
// checks every edge; hand sequences cover async reset and the minimal config.
module tb_reset_sequencer;

  logic clk = 1'b0;
  logic clk_en = 1'b1;
  always #5 if (clk_en) clk = ~clk;

  logic       arstn, lock, sw;
  logic [3:0] srst;
  logic       rdy;
  logic [2:0] st;

  logic       arstn1, lock1, sw1;
  logic [0:0] srst1;
  logic       rdy1;
  logic [2:0] st1;

  reset_sequencer #(.OUT_RST_ACTIVE(4'b0101)) dut (
    .i_clk(clk), .i_arstn(arstn), .i_lock(lock), .i_sw_rst(sw),
    .o_srst(srst), .o_ready(rdy), .o_state(st)
  );

  reset_sequencer #(.NUM_OUT(1), .HOLD_CYCLES(1), .LOCK_FILTER(1)) dut1 (
    .i_clk(clk), .i_arstn(arstn1), .i_lock(lock1), .i_sw_rst(sw1),
    .o_srst(srst1), .o_ready(rdy1), .o_state(st1)
  );

  typedef struct {
    int         n;
    logic       rstn, lock, sw;
    logic [3:0] srst;
    logic       rdy;
    logic [2:0] st;
  } seg_t;

  typedef struct {
    int         step;
    logic [3:0] srst;
    logic       rdy;
    logic [2:0] st;
  } exp_t;

  int   n_chk  = 0;
  int   n_fail = 0;
  int   step_no = 0;
  exp_t sb[$];
  seg_t tbl_a[$], tbl_b[$];

  localparam logic [3:0] A  = 4'b0101;  // all asserted
  localparam logic [3:0] R0 = 4'b0100;
  localparam logic [3:0] R1 = 4'b0110;
  localparam logic [3:0] R2 = 4'b0010;
  localparam logic [3:0] R3 = 4'b1010;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic seg_t S(input int n, input logic r, input logic l, input logic s,
                             input logic [3:0] o, input logic rd, input logic [2:0] t);
    seg_t x;
    x.n = n; x.rstn = r; x.lock = l; x.sw = s; x.srst = o; x.rdy = rd; x.st = t;
    return x;
  endfunction

  task automatic drive_step(input seg_t s);
    exp_t e;
    @(negedge clk);
    arstn = s.rstn; lock = s.lock; sw = s.sw;
    step_no++;
    e.step = step_no; e.srst = s.srst; e.rdy = s.rdy; e.st = s.st;
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic run_tbl(input seg_t q[$]);
    foreach (q[i]) for (int k = 0; k < q[i].n; k++) drive_step(q[i]);
  endtask

  always @(posedge clk) begin : mon
    exp_t e;
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk($sformatf("step%0d srst", e.step), 32'(srst), 32'(e.srst));
      chk($sformatf("step%0d ready", e.step), 32'(rdy), 32'(e.rdy));
      chk($sformatf("step%0d state", e.step), 32'(st), 32'(e.st));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Bring-up, with sw_rst held in RESET/WAIT_LOCK where it must be ignored.
    tbl_a.push_back(S(2,  1, 1, 1, A,  0, 3'd0));
    tbl_a.push_back(S(4,  1, 1, 1, A,  0, 3'd1));
    tbl_a.push_back(S(16, 1, 1, 0, A,  0, 3'd2));
    tbl_a.push_back(S(8,  1, 1, 0, R0, 0, 3'd3));
    tbl_a.push_back(S(8,  1, 1, 0, R1, 0, 3'd3));
    tbl_a.push_back(S(8,  1, 1, 0, R2, 0, 3'd3));
    tbl_a.push_back(S(3,  1, 1, 0, R3, 1, 3'd4));
    // One-cycle lock drop in RUN: lock_ok falls two edges later.
    tbl_a.push_back(S(1,  1, 0, 0, R3, 1, 3'd4));
    tbl_a.push_back(S(2,  1, 1, 0, R3, 1, 3'd4));
    tbl_a.push_back(S(4,  1, 1, 0, A,  0, 3'd1));
    tbl_a.push_back(S(16, 1, 1, 0, A,  0, 3'd2));
    tbl_a.push_back(S(8,  1, 1, 0, R0, 0, 3'd3));
    tbl_a.push_back(S(3,  1, 1, 0, R1, 0, 3'd3));
    // sw_rst pulse in RELEASE, then sw_rst held in HOLD keeps the count at zero.
    tbl_a.push_back(S(1,  1, 1, 1, A,  0, 3'd2));
    tbl_a.push_back(S(5,  1, 1, 0, A,  0, 3'd2));
    tbl_a.push_back(S(5,  1, 1, 1, A,  0, 3'd2));
    tbl_a.push_back(S(15, 1, 1, 0, A,  0, 3'd2));
    tbl_a.push_back(S(8,  1, 1, 0, R0, 0, 3'd3));
    tbl_a.push_back(S(8,  1, 1, 0, R1, 0, 3'd3));
    tbl_a.push_back(S(8,  1, 1, 0, R2, 0, 3'd3));
    tbl_a.push_back(S(3,  1, 1, 0, R3, 1, 3'd4));
    // sw_rst timed to coincide with lock_ok falling: lock loss wins.
    tbl_a.push_back(S(1,  1, 0, 0, R3, 1, 3'd4));
    tbl_a.push_back(S(2,  1, 1, 0, R3, 1, 3'd4));
    tbl_a.push_back(S(1,  1, 1, 1, A,  0, 3'd1));
    tbl_a.push_back(S(3,  1, 1, 0, A,  0, 3'd1));
    tbl_a.push_back(S(6,  1, 1, 0, A,  0, 3'd2));
    // Restart after the mid-HOLD async reset.
    tbl_b.push_back(S(2,  1, 1, 0, A,  0, 3'd0));
    tbl_b.push_back(S(4,  1, 1, 0, A,  0, 3'd1));
    tbl_b.push_back(S(16, 1, 1, 0, A,  0, 3'd2));
    tbl_b.push_back(S(8,  1, 1, 0, R0, 0, 3'd3));
    tbl_b.push_back(S(8,  1, 1, 0, R1, 0, 3'd3));
    tbl_b.push_back(S(8,  1, 1, 0, R2, 0, 3'd3));
    tbl_b.push_back(S(2,  1, 1, 0, R3, 1, 3'd4));

    arstn = 1'b0; lock = 1'b1; sw = 1'b0;
    arstn1 = 1'b0; lock1 = 1'b1; sw1 = 1'b0;
    #12;
    chk("reset srst", 32'(srst), 32'(A));
    chk("reset ready", 32'(rdy), 32'd0);
    chk("reset state", 32'(st), 32'd0);
    chk("min reset srst", 32'(srst1), 32'd1);

    // Minimal config: release on the edge right after HOLD entry.
    @(negedge clk) arstn1 = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("min e2 state", 32'(st1), 32'd0);
    @(posedge clk); #1 chk("min e3 state", 32'(st1), 32'd1);
    @(posedge clk); #1;
    chk("min e4 state", 32'(st1), 32'd2);
    chk("min e4 srst", 32'(srst1), 32'd1);
    chk("min e4 ready", 32'(rdy1), 32'd0);
    @(posedge clk); #1;
    chk("min e5 state", 32'(st1), 32'd4);
    chk("min e5 srst", 32'(srst1), 32'd0);
    chk("min e5 ready", 32'(rdy1), 32'd1);
    #2 arstn1 = 1'b0;
    #1;
    chk("min async state", 32'(st1), 32'd0);
    chk("min async srst", 32'(srst1), 32'd1);
    chk("min async ready", 32'(rdy1), 32'd0);

    run_tbl(tbl_a);

    // Async reset between edges, mid-HOLD, then with the clock stopped.
    #1 arstn = 1'b0;
    #1;
    chk("async state", 32'(st), 32'd0);
    chk("async srst", 32'(srst), 32'(A));
    chk("async ready", 32'(rdy), 32'd0);
    @(negedge clk) clk_en = 1'b0;
    #200;
    chk("stopped state", 32'(st), 32'd0);
    chk("stopped srst", 32'(srst), 32'(A));
    clk_en = 1'b1;

    run_tbl(tbl_b);
    chk("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameters SHALL be:
- NUM_OUT, 4, number of sequenced reset outputs (1..8).
- SYNC_STAGES, 2, flops in reset-deassert synchroniser (2..4).
- LOCK_FILTER, 4, consecutive synchronised i_lock-high cycles needed to accept lock (1..255).
- HOLD_CYCLES, 16, cycles all outputs stay asserted after lock accepted (1..65535).
- STAGE_GAP, 8, cycles between successive channel releases (1..65535).
- OUT_RST_ACTIVE, {NUM_OUT{1'b1}}, per-channel output polarity; bit=1 active-high, 0 active-low.

REQ-002 Ports SHALL be:
- i_clk  in  1  single clock.
- i_arstn  in  1  asynchronous reset, active-low.
- i_lock  in  1  PLL/clock-good, asynchronous to i_clk.
- i_sw_rst  in  1  synchronous software reset request, level, active-high.
- o_srst  out  NUM_OUT  sequenced synchronous resets, polarity per OUT_RST_ACTIVE.
- o_ready  out  1  high when all channels released.
- o_state  out  3  current FSM state encoding.

Function
REQ-003 "Asserted" for o_srst[k] SHALL mean 1 if OUT_RST_ACTIVE[k]=1, else 0; all outputs SHALL be registered.
REQ-004 i_arstn low SHALL assert every o_srst, clear o_ready and force state RESET asynchronously, without a clock edge.
REQ-005 Deassertion of i_arstn SHALL pass through a SYNC_STAGES-flop chain; FSM leaves RESET on the first edge after the chain output deasserts.
REQ-006 i_lock SHALL pass through a 2-flop synchroniser; a filter counter saturating at LOCK_FILTER SHALL increment on each cycle the synchronised lock is 1 and clear to 0 on any cycle it is 0; lock_ok = (counter == LOCK_FILTER).
REQ-007 States and encodings SHALL be: RESET=0, WAIT_LOCK=1, HOLD=2, RELEASE=3, RUN=4; o_state SHALL reflect the registered state.
REQ-008 WAIT_LOCK -> HOLD on the edge where lock_ok=1; all outputs remain asserted.
REQ-009 HOLD SHALL clear a hold counter on entry and increment it each cycle; on the edge where counter = HOLD_CYCLES-1, go to RELEASE and deassert o_srst[0] on that same edge.
REQ-010 RELEASE SHALL deassert o_srst[k+1] exactly STAGE_GAP edges after o_srst[k], in ascending index order; released channels stay released.
REQ-011 On the edge that releases o_srst[NUM_OUT-1], state SHALL go to RUN and o_ready SHALL go to 1; with NUM_OUT=1 this is the HOLD-exit edge.
REQ-012 In WAIT_LOCK, HOLD, RELEASE or RUN, lock_ok=0 SHALL, on the next edge, re-assert all outputs, clear o_ready and go to WAIT_LOCK.
REQ-013 i_sw_rst=1 in HOLD, RELEASE or RUN SHALL, on the next edge, re-assert all outputs, clear o_ready, go to HOLD and clear the hold counter; holding i_sw_rst high SHALL keep the counter at 0.
REQ-014 i_sw_rst in RESET or WAIT_LOCK SHALL be ignored.
REQ-015 Simultaneous lock loss and i_sw_rst SHALL resolve as lock loss (REQ-012).
REQ-016 Hold and gap counters SHALL be sized to hold their parameter value without wrap; no counter SHALL wrap or overflow in any state.

Reset
REQ-017 During and after i_arstn low until FSM progresses: o_srst all asserted, o_ready=0, o_state=0, lock filter=0, all counters=0, synchroniser flops reset.
REQ-018 i_arstn asserted mid-sequence (any state) SHALL apply REQ-017 immediately; the sequence SHALL restart from RESET on deassertion.

Verification
REQ-019 Defaults, OUT_RST_ACTIVE=4'b0101, i_lock high, release i_arstn -> o_state 0->1->2 after sync and filter; o_srst=4'b0101 until release; o_srst[0] falls 16 edges after HOLD entry, [1],[2],[3] change at +8 edge spacing; o_ready=1 with o_state=4 on the [3] edge.
REQ-020 In RUN, drop i_lock for 1 cycle -> next edge after lock_ok falls: all asserted, o_state=1; re-lock requires 4 consecutive lock cycles, then full HOLD/RELEASE sequence repeats.
REQ-021 In RELEASE after o_srst[1] released, pulse i_sw_rst 1 cycle -> next edge all asserted, o_state=2; o_srst[0] released 16 edges later.
REQ-022 In RUN, assert i_sw_rst and drop i_lock on same cycle -> o_state=1 (WAIT_LOCK), not 2.
REQ-023 Assert i_arstn low mid-HOLD between clock edges -> outputs asserted, o_state=0 before next edge; clock stopped during reset -> outputs remain asserted.
REQ-024 NUM_OUT=1, HOLD_CYCLES=1, LOCK_FILTER=1 -> o_srst[0] released and o_ready=1 on the HOLD-exit edge, one edge after HOLD entry.
